// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS load/store bus and data memory.
// FSM encoding, sizing constants, lane helpers, trace text format.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

  localparam int DM_DEPTH_WORDS = 3072;
  localparam int LANE_W         = 8;
  localparam int LANES          = 4;

  localparam string TRACE_FMT = "@%h: *%h <= %h";

  function automatic logic [31:0] be_mask(
    input logic [3:0] be
  );
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i*LANE_W +: LANE_W] = {LANE_W{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Load/store bus between the CPU core (master) and data memory (slave).
// req_*: request channel, rsp_*: response channel, both valid/ready.
interface dm_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_be, req_pc,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_be, req_pc,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_array.sv
// Word storage with byte-enabled write and read-before-write port.
// clk/reset, i_en/i_we/i_idx/i_wdata/i_be in, o_rdata = old word out.
module dm_array
  import mips_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // The read register only moves on an access, so it holds the
  // accessed word until the next request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= r_mem[i_idx];
      if (i_we) begin
        for (int l = 0; l < LANES; l++) begin
          if (i_be[l]) begin
            r_mem[i_idx][l*LANE_W +: LANE_W] <=
              i_wdata[l*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: latency FSM, response and store trace.
// clk/reset, bus (slave), trace_valid/pc/addr/data out.
module dm_responder
  import mips_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int LATENCY     = 1
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus,
  output logic           trace_valid,
  output logic [31:0]    trace_pc,
  output logic [31:0]    trace_addr,
  output logic [31:0]    trace_data
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT    = 32'(4 * DEPTH_WORDS);
  localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

  dm_state_e   r_state;
  logic [2:0]  r_cnt;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_pc;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_trace_valid;
  logic [31:0] r_trace_pc;
  logic [31:0] r_trace_addr;
  logic [31:0] r_trace_data;

  logic          w_accept;
  logic          w_in_range;
  logic          w_hs;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;
  logic [31:0]   w_mask;
  logic [31:0]   w_merged;

  assign w_accept   = bus.req_valid & r_req_ready;
  assign w_in_range = bus.req_addr < LIMIT;
  assign w_idx      = bus.req_addr[AW+1:2];
  assign w_hs       = r_rsp_valid & bus.rsp_ready;

  dm_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_accept & w_in_range),
    .i_we    (bus.req_we),
    .i_idx   (w_idx),
    .i_wdata (bus.req_wdata),
    .i_be    (bus.req_be),
    .o_rdata (w_rdata)
  );

  // w_rdata holds the pre-store word, so the merged
  // result is rebuilt here instead of re-reading memory.
  assign w_mask   = be_mask(r_be);
  assign w_merged = (w_rdata & ~w_mask) | (r_wdata & w_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_we          <= 1'b0;
      r_err         <= 1'b0;
      r_addr        <= '0;
      r_pc          <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_trace_valid <= 1'b0;
      r_trace_pc    <= '0;
      r_trace_addr  <= '0;
      r_trace_data  <= '0;
    end else begin
      r_trace_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_err       <= ~w_in_range;
            r_addr      <= {bus.req_addr[31:2], 2'b00};
            r_pc        <= bus.req_pc;
            r_wdata     <= bus.req_wdata;
            r_be        <= bus.req_be;
            r_req_ready <= 1'b0;
            if (LATENCY > 1) begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_INIT;
            end else begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd1) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (w_hs) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            if (r_we && !r_err) begin
              r_trace_valid <= 1'b1;
              r_trace_pc    <= r_pc;
              r_trace_addr  <= r_addr;
              r_trace_data  <= w_merged;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_valid & r_err;
  assign bus.rsp_rdata =
    (r_rsp_valid && !r_we && !r_err) ? w_rdata : '0;

  assign trace_valid = r_trace_valid;
  assign trace_pc    = r_trace_pc;
  assign trace_addr  = r_trace_addr;
  assign trace_data  = r_trace_data;

endmodule
